// File: rtl/display_scan_ctrl.sv
// Scan controller for an N-digit common-select 7-segment bank.
// It presents one digit per time slot to the shared segment decoder and drives
// the one-hot digit enables. Each slot starts with a short blanking interval.
// Digits are double-buffered: the host fills a shadow bank, and a commit copies
// it to the displayed (active) bank only at a frame boundary, so a frame never
// shows a mix of old and new digits.
module display_scan_ctrl #(
    parameter int N_DIG = 4,
    parameter int PRESC = 1000,
    parameter int BLANK = 2,
    parameter int AW    = (N_DIG <= 2) ? 1 : $clog2(N_DIG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [3:0]       wr_data,
    input  logic             wr_dp,
    input  logic             commit,
    input  logic             lz_blank,
    output logic [3:0]       digit_val,
    output logic             digit_dp,
    output logic [N_DIG-1:0] digit_en,
    output logic             commit_pend,
    output logic             commit_done
);

    localparam int PW = $clog2(PRESC);

    logic [PW-1:0] presc_cnt_reg, presc_cnt_next;
    logic [AW-1:0] sel_reg, sel_next;
    logic          commit_pend_reg, commit_pend_next;
    logic          commit_done_reg, commit_done_next;
    logic          en_reg;
    logic          lz_reg;

    logic [3:0]    shadow_code_reg [N_DIG];
    logic          shadow_dp_reg   [N_DIG];
    logic [3:0]    active_code_reg [N_DIG];
    logic          active_dp_reg   [N_DIG];

    logic          advance;
    logic          slot_end;
    logic          frame_end;
    logic          transfer;
    logic          blank_phase;
    logic [N_DIG-1:0] is_zero;
    logic [N_DIG-1:0] zero_from;
    logic [N_DIG-1:0] suppress;

    // The scan only moves once enable has been seen for a full cycle, so that
    // after a restart slot 0 begins with its complete blanking interval.
    assign advance   = enable && en_reg;
    assign slot_end  = (presc_cnt_reg == PW'(PRESC - 1));
    assign frame_end = slot_end && (sel_reg == AW'(N_DIG - 1));
    // A pending commit lands at the frame boundary, or right away when dark.
    assign transfer  = commit_pend_reg && (!enable || (advance && frame_end));

    // Next-state logic for the scan counters and the commit handshake.
    always_comb begin
        presc_cnt_next   = presc_cnt_reg;
        sel_next         = sel_reg;
        commit_pend_next = commit_pend_reg;
        commit_done_next = transfer;
        if (!enable) begin
            presc_cnt_next = '0;
            sel_next       = '0;
        end else if (advance) begin
            if (slot_end) begin
                presc_cnt_next = '0;
                sel_next       = (sel_reg == AW'(N_DIG - 1)) ? '0 : sel_reg + 1'b1;
            end else begin
                presc_cnt_next = presc_cnt_reg + 1'b1;
            end
        end
        // A commit arriving while the transfer happens is absorbed, not queued.
        if (transfer) begin
            commit_pend_next = 1'b0;
        end else if (commit) begin
            commit_pend_next = 1'b1;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt_reg   <= '0;
            sel_reg         <= '0;
            commit_pend_reg <= 1'b0;
            commit_done_reg <= 1'b0;
            en_reg          <= 1'b0;
            lz_reg          <= 1'b0;
        end else begin
            presc_cnt_reg   <= presc_cnt_next;
            sel_reg         <= sel_next;
            commit_pend_reg <= commit_pend_next;
            commit_done_reg <= commit_done_next;
            en_reg          <= enable;
            lz_reg          <= lz_blank;
        end
    end

    // Shadow and active digit banks; the active bank copies the shadow values
    // as they stood before any write landing on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_DIG; i++) begin
                shadow_code_reg[i] <= 4'h0;
                shadow_dp_reg[i]   <= 1'b0;
                active_code_reg[i] <= 4'h0;
                active_dp_reg[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < N_DIG; i++) begin
                if (wr_en && (wr_addr == AW'(i))) begin
                    shadow_code_reg[i] <= wr_data;
                    shadow_dp_reg[i]   <= wr_dp;
                end
                if (transfer) begin
                    active_code_reg[i] <= shadow_code_reg[i];
                    active_dp_reg[i]   <= shadow_dp_reg[i];
                end
            end
        end
    end

    // Blanking window at the head of every slot (absent when BLANK is 0).
    generate
        if (BLANK == 0) begin : g_no_blank
            assign blank_phase = 1'b0;
        end else begin : g_blank
            assign blank_phase = (presc_cnt_reg < PW'(BLANK));
        end
    endgenerate

    // Leading-zero chain: zero_from[i] means digit i and all above it are blank.
    genvar gi;
    generate
        for (gi = 0; gi < N_DIG; gi++) begin : g_digit
            assign is_zero[gi] = (active_code_reg[gi] == 4'h0) && !active_dp_reg[gi];
            if (gi == N_DIG - 1) begin : g_top
                assign zero_from[gi] = is_zero[gi];
            end else begin : g_mid
                assign zero_from[gi] = is_zero[gi] && zero_from[gi+1];
            end
            if (gi == 0) begin : g_lsd
                assign suppress[gi] = 1'b0;
            end else begin : g_upper
                assign suppress[gi] = lz_reg && zero_from[gi];
            end
            assign digit_en[gi] = en_reg && !blank_phase &&
                                  (sel_reg == AW'(gi)) && !suppress[gi];
        end
    endgenerate

    assign digit_val   = active_code_reg[sel_reg];
    assign digit_dp    = active_dp_reg[sel_reg];
    assign commit_pend = commit_pend_reg;
    assign commit_done = commit_done_reg;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with N_DIG=4, PRESC=4, BLANK=1.
// Inputs change just after the falling edge; outputs are checked there too.
module tb_display_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_dp;
    logic       commit;
    logic       lz_blank;
    logic [3:0] digit_val;
    logic       digit_dp;
    logic [3:0] digit_en;
    logic       commit_pend;
    logic       commit_done;

    int checks = 0;
    int errors = 0;
    int c;      // cycle index since scan start: presc = c%4, sel = (c/4)%4

    display_scan_ctrl #(.N_DIG(4), .PRESC(4), .BLANK(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_dp      (wr_dp),
        .commit     (commit),
        .lz_blank   (lz_blank),
        .digit_val  (digit_val),
        .digit_dp   (digit_dp),
        .digit_en   (digit_en),
        .commit_pend(commit_pend),
        .commit_done(commit_done)
    );

    always #5 clk = ~clk;

    // Reference decoder: {dp,a,b,c,d,e,f,g}, active-high.
    function automatic logic [7:0] seg7(input logic dp, input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1111110; 4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101; 4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011; 4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111; 4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111; 4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111; 4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110; 4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111; default: s = 7'b1000111;
        endcase
        return {dp, s};
    endfunction

    // Expected enables for a plain scan without suppression.
    function automatic logic [3:0] scan_en(input int cyc);
        if ((cyc % 4) == 0) return 4'b0000;
        return 4'(1 << ((cyc / 4) % 4));
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s c=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        c++;
    endtask

    task automatic goto(input int target);
        int guard = 0;
        while (c < target && guard < 1000) begin
            step();
            guard++;
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 4'h0;
        wr_dp = 1'b0; commit = 1'b0; lz_blank = 1'b0; c = -100;
        @(negedge clk);
        @(negedge clk);
        check("rst_en",   {4'b0, digit_en}, 8'h00);
        check("rst_val",  {4'b0, digit_val}, 8'h00);
        check("rst_dp",   {7'b0, digit_dp}, 8'h00);
        check("rst_pend", {7'b0, commit_pend}, 8'h00);
        check("rst_done", {7'b0, commit_done}, 8'h00);

        // Plain scan: two full frames.
        rst = 1'b0;
        c = -1;
        step();
        for (int k = 0; k < 32; k++) begin
            check("scan_en", {4'b0, digit_en}, {4'b0, scan_en(c)});
            if (k != 31) step();
        end

        // Fill the shadow bank mid-frame, then commit.
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'h5; wr_dp = 1'b0; step();
        wr_addr = 2'd1; wr_data = 4'hA; wr_dp = 1'b1; step();
        wr_addr = 2'd2; wr_data = 4'h3; wr_dp = 1'b0; step();
        wr_addr = 2'd3; wr_data = 4'h0; wr_dp = 1'b0; step();
        wr_en = 1'b0; commit = 1'b1; step();
        commit = 1'b0;
        check("cm_pend1", {7'b0, commit_pend}, 8'h01);
        check("cm_done0", {7'b0, commit_done}, 8'h00);
        check("cm_oldval", {4'b0, digit_val}, 8'h00);
        goto(47);
        check("cm_pend_bnd", {7'b0, commit_pend}, 8'h01);
        check("cm_done_bnd", {7'b0, commit_done}, 8'h00);
        step();
        check("cm_done1", {7'b0, commit_done}, 8'h01);
        check("cm_pend0", {7'b0, commit_pend}, 8'h00);
        check("cm_val0", {4'b0, digit_val}, 8'h05);
        check("cm_blank0", {4'b0, digit_en}, 8'h00);
        step();
        check("cm_done_end", {7'b0, commit_done}, 8'h00);
        check("cm_en0", {4'b0, digit_en}, 8'h01);
        check("cm_seg5", seg7(digit_dp, digit_val), 8'b0_1011011);
        goto(53);
        check("cm_val1", {4'b0, digit_val}, 8'h0A);
        check("cm_dp1", {7'b0, digit_dp}, 8'h01);
        check("cm_en1", {4'b0, digit_en}, 8'h02);
        goto(57);
        check("cm_val2", {4'b0, digit_val}, 8'h03);
        check("cm_dp2", {7'b0, digit_dp}, 8'h00);
        check("cm_en2", {4'b0, digit_en}, 8'h04);
        goto(61);
        check("cm_val3", {4'b0, digit_val}, 8'h00);
        check("cm_en3", {4'b0, digit_en}, 8'h08);

        // Leading-zero pattern 0,0,7,0 (d3..d0).
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'h0; wr_dp = 1'b0; step();
        wr_addr = 2'd1; wr_data = 4'h7; step();
        wr_addr = 2'd2; wr_data = 4'h0; step();
        wr_en = 1'b0; commit = 1'b1; step();
        commit = 1'b0; lz_blank = 1'b1;
        goto(80);
        check("lz_done", {7'b0, commit_done}, 8'h01);
        for (int k = 0; k < 16; k++) begin
            check("lz_en", {4'b0, digit_en},
                  {4'b0, (((c / 4) % 4) <= 1) ? scan_en(c) : 4'b0000});
            if (c == 85) check("lz_val1", {4'b0, digit_val}, 8'h07);
            if (k != 15) step();
        end
        lz_blank = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step();
            check("nolz_en", {4'b0, digit_en}, {4'b0, scan_en(c)});
        end

        // Commit on the boundary cycle itself is deferred one frame.
        commit = 1'b1; step();
        commit = 1'b0;
        check("race_pend", {7'b0, commit_pend}, 8'h01);
        check("race_nodone", {7'b0, commit_done}, 8'h00);
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 4'h4; step();
        wr_en = 1'b0;
        goto(127);
        check("race_pend_bnd", {7'b0, commit_pend}, 8'h01);
        check("race_done_bnd", {7'b0, commit_done}, 8'h00);
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'h8; step();
        wr_en = 1'b0;
        check("race_done", {7'b0, commit_done}, 8'h01);
        check("race_pend0", {7'b0, commit_pend}, 8'h00);
        check("race_oldd0", {4'b0, digit_val}, 8'h00);
        goto(137);
        check("race_val2", {4'b0, digit_val}, 8'h04);
        check("race_en2", {4'b0, digit_en}, 8'h04);

        // Drop enable with a commit pending while digit 2 is shown.
        commit = 1'b1; step();
        commit = 1'b0;
        check("en_pend", {7'b0, commit_pend}, 8'h01);
        enable = 1'b0; step();
        check("dis_en", {4'b0, digit_en}, 8'h00);
        check("dis_done", {7'b0, commit_done}, 8'h01);
        check("dis_pend", {7'b0, commit_pend}, 8'h00);
        check("dis_val", {4'b0, digit_val}, 8'h08);
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'h2; step();
        wr_en = 1'b0;
        check("dis_done_end", {7'b0, commit_done}, 8'h00);
        check("dis_en2", {4'b0, digit_en}, 8'h00);
        enable = 1'b1; step();
        check("reen_blank", {4'b0, digit_en}, 8'h00);
        check("reen_val", {4'b0, digit_val}, 8'h08);
        step();
        check("reen_d0", {4'b0, digit_en}, 8'h01);

        // Reset with a commit pending.
        commit = 1'b1; step();
        commit = 1'b0;
        check("rm_pend", {7'b0, commit_pend}, 8'h01);
        rst = 1'b1; step();
        check("rm_pend0", {7'b0, commit_pend}, 8'h00);
        check("rm_done0", {7'b0, commit_done}, 8'h00);
        check("rm_en0", {4'b0, digit_en}, 8'h00);
        check("rm_val0", {4'b0, digit_val}, 8'h00);
        rst = 1'b0; step();
        check("rm_blank", {4'b0, digit_en}, 8'h00);
        check("rm_nodone", {7'b0, commit_done}, 8'h00);
        step();
        check("rm_d0", {4'b0, digit_en}, 8'h01);
        check("rm_active0", {4'b0, digit_val}, 8'h00);
        check("rm_nodone2", {7'b0, commit_done}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
